// File: rtl/alarm_pkg.sv
// Shared definitions for the car-alarm timer: interval encodings,
// timer state encoding and the width of a programmable time value.
package alarm_pkg;

    localparam int TIME_W = 4;

    typedef logic [TIME_W-1:0] time_t;
    typedef logic [1:0]        interval_t;

    localparam interval_t INT_ARM       = 2'd0;
    localparam interval_t INT_DRIVER    = 2'd1;
    localparam interval_t INT_PASSENGER = 2'd2;
    localparam interval_t INT_ALARM     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_EXPIRE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/alarm_timer_sequencer_tick_divider.sv
// Free-running one-second prescaler. Counts 0..TICK_DIV-1 and flags the
// last count as the tick; a clear restarts the second from zero.
module tick_divider #(
    parameter int TICK_DIV = 27_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Advance the prescaler, wrapping at the last count; clear restarts the second.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (r_count == LAST) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Tick is decoded from the counter register only, so it carries no input path.
    assign tick = (r_count == LAST);

endmodule

// File: rtl/alarm_timer_sequencer.sv
// Countdown sequencer for the car-alarm FSM. Holds the four programmable
// delays, runs the selected interval at one-second resolution and returns
// a one-cycle expired pulse. All outputs come straight from registers.
module alarm_timer_sequencer
    import alarm_pkg::*;
#(
    parameter int TICK_DIV            = 27_000_000,
    parameter int T_ARM_DEFAULT       = 6,
    parameter int T_DRIVER_DEFAULT    = 8,
    parameter int T_PASSENGER_DEFAULT = 15,
    parameter int T_ALARM_DEFAULT     = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       blink
);

    time_t        r_param [4];
    timer_state_t r_state;
    time_t        r_remaining;
    logic         r_expired;
    logic         r_busy;
    logic         r_blink;

    logic         w_tick;
    time_t        w_start_value;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .clear (start_timer),
        .tick  (w_tick)
    );

    // The parameter file is read here with the pre-write contents, so a
    // same-edge reprogram of the selected entry does not affect this start.
    assign w_start_value = r_param[interval];

    // Parameter file: defaults on reset, single-entry write on reprogram.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_param[INT_ARM]       <= TIME_W'(T_ARM_DEFAULT);
            r_param[INT_DRIVER]    <= TIME_W'(T_DRIVER_DEFAULT);
            r_param[INT_PASSENGER] <= TIME_W'(T_PASSENGER_DEFAULT);
            r_param[INT_ALARM]     <= TIME_W'(T_ALARM_DEFAULT);
        end else if (reprogram) begin
            r_param[time_param_sel] <= time_value;
        end
    end

    // Countdown FSM; a start always wins over tick or expiry so a restarted
    // interval never lets the old one fire.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= TIME_W'(0);
            r_expired   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_timer) begin
                        r_remaining <= w_start_value;
                        r_state     <= ST_COUNT;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (start_timer) begin
                        r_remaining <= w_start_value;
                        r_state     <= ST_COUNT;
                        r_busy      <= 1'b1;
                    end else if (r_remaining == TIME_W'(0)) begin
                        r_state   <= ST_EXPIRE;
                        r_expired <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_tick) begin
                        if (r_remaining == TIME_W'(1)) begin
                            r_remaining <= TIME_W'(0);
                            r_state     <= ST_EXPIRE;
                            r_expired   <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_remaining <= r_remaining - TIME_W'(1);
                        end
                    end else begin
                        r_state <= ST_COUNT;
                    end
                end
                ST_EXPIRE: begin
                    if (start_timer) begin
                        r_remaining <= w_start_value;
                        r_state     <= ST_COUNT;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_remaining <= TIME_W'(0);
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Status LED blink: toggles on every one-second tick in any state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink <= 1'b0;
        end else if (w_tick) begin
            r_blink <= ~r_blink;
        end else begin
            r_blink <= r_blink;
        end
    end

    assign expired   = r_expired;
    assign busy      = r_busy;
    assign remaining = r_remaining;
    assign blink     = r_blink;

endmodule

// File: doc/alarm_timer_sequencer.md
# alarm_timer_sequencer

Programmable countdown timer controller for the car-alarm FSM. It stores the four user-programmable time parameters (arm delay, driver-door delay, passenger-door delay, siren duration) and sequences the one-second countdown when the FSM requests a named interval. It returns a one-cycle `expired` pulse to the FSM's `timer_status` input and sits between the FSM, the user switch/button interface and the status LEDs.

## Interface
- `TICK_DIV`, 27_000_000: clock cycles per one-second tick (set to 4 in simulation)
- `T_ARM_DEFAULT`, 6: arm-delay reset value, seconds
- `T_DRIVER_DEFAULT`, 8: driver-door delay reset value
- `T_PASSENGER_DEFAULT`, 15: passenger-door delay reset value
- `T_ALARM_DEFAULT`, 10: siren-on reset value

- `clock` in 1: system clock
- `reset` in 1: reset, synchronous, active-high; clock `clock`
- `start_timer` in 1: one-cycle request that loads and starts the selected interval
- `interval` in 2: 0 arm, 1 driver, 2 passenger, 3 alarm; sampled with `start_timer`
- `reprogram` in 1: one-cycle write strobe for the parameter file
- `time_param_sel` in 2: parameter index for `reprogram`, same encoding as `interval`
- `time_value` in 4: new value in seconds (0–15)
- `expired` out 1: one-cycle pulse when the running interval reaches zero
- `busy` out 1: high while counting
- `remaining` out 4: seconds left
- `blink` out 1: toggles on every one-second tick, for the status LED

## Operation
- Parameter file: four 4-bit registers. Reset loads the `T_*_DEFAULT` values.
  - `reprogram` writes `time_value` into entry `time_param_sel` at the next edge.
- FSM states: IDLE, COUNT, EXPIRE.
- IDLE:
  - `start_timer` loads `remaining` with `param[interval]`, clears the divider and moves to COUNT.
- COUNT:
  - The tick fires when the divider equals `TICK_DIV-1`.
  - On a tick, `remaining` decrements.
  - A tick with `remaining`==1, or entry with `remaining`==0, sets `remaining` to 0 and moves to EXPIRE.
  - `start_timer` in COUNT restarts: it reloads `remaining` and clears the divider. The old interval never produces `expired`.
- EXPIRE: `expired`=1 for exactly one cycle, then IDLE.
  - `start_timer` in EXPIRE is honoured: the pulse still issues, and the state goes to COUNT instead of IDLE.
- Divider: 0..`TICK_DIV-1`, free-running in every state, cleared only by `start_timer` and reset.
  - `blink` toggles on every tick, including in IDLE.
- `busy` = (state==COUNT).
- Simultaneous `reprogram` and `start_timer` on the same index: `start_timer` loads the old value. The file is read before it is written.
- `reprogram` while counting does not change `remaining`.
- `interval` is ignored unless `start_timer` is high.

## Timing
- Reset values: `expired`=0, `busy`=0, `remaining`=0, `blink`=0, state IDLE, divider 0, parameters at defaults.
- Reset mid-count aborts without emitting `expired`.
- Latency: for a start sampled at edge E0 with value P≥1:
  - decrements happen at edges E0+k·`TICK_DIV`;
  - `expired` is high in the cycle after edge E0+P·`TICK_DIV`.
- P=0: `expired` is high in the cycle after edge E0+1.
- `busy` falls on the same edge that raises `expired`.
- All outputs are registered; there are no combinational paths from inputs.

## Structure
- Shared package `alarm_pkg`:
  - interval encodings `INT_ARM`, `INT_DRIVER`, `INT_PASSENGER`, `INT_ALARM`;
  - timer state encoding;
  - the 4-bit time-value width constant.
- The FSM imports the same interval encodings.
- One sub-module, `tick_divider`: parameter `TICK_DIV`, inputs `clock`/`reset`/`clear`, output one-cycle `tick`.
- The parameter file and the countdown stay in the top level.

## Test plan
- `TICK_DIV`=4, reset, start `interval`=0 → `remaining` steps 6,5,…,0; `busy` high throughout; `expired` single pulse after edge E0+24.
- `reprogram` `time_param_sel`=2 `time_value`=3, then start `interval`=2 → `expired` after edge E0+12; the other parameters are unchanged.
- Start arm; at `remaining`=3, start `interval`=1 → `remaining`=8; exactly one `expired`, 32 edges after the second start.
- Program arm to 0, start arm → `expired` one cycle after E0+1; `busy` never high past E0+1.
- Reset during COUNT → next cycle `busy`=0, `remaining`=0, no `expired`; passenger parameter restored to 15.
- Same-edge `reprogram` (sel 3, value 2) and start `interval`=3 → counts from 10; the following start of `interval`=3 counts from 2.
